// File: rtl/apb_wdt.sv
// APB3 watchdog: prescaled down-counter that interrupts on the first timeout and
// requests a system reset on a second unserviced timeout. Config is key-locked.
module apb_wdt #(
   parameter int CNT_W = 32,
   parameter int PSC_W = 8
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [2:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        WDOGINT,
   output logic        WDOGRES
);

   typedef enum logic [2:0] {
      A_LOAD   = 3'd0,
      A_VALUE  = 3'd1,
      A_CTRL   = 3'd2,
      A_INTCLR = 3'd3,
      A_RIS    = 3'd4,
      A_LOCK   = 3'd5
   } reg_addr_e;

   localparam logic [31:0]      UNLOCK_KEY = 32'h1ACC_E551;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PSC_W-1:0] PSC_ONE    = {{(PSC_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] load_q;
   logic [CNT_W-1:0] value_q;
   logic [PSC_W-1:0] psc_q;
   logic [PSC_W-1:0] psc_cnt;
   logic             resen_q;
   logic             inten_q;
   logic             int_raw;
   logic             locked;
   logic             wdogres_q;

   logic             access;
   logic             wr_en;
   logic             wr_load;
   logic             wr_ctrl;
   logic             wr_intclr;
   logic             wr_lock;
   logic             tick;
   logic [31:0]      rd_data;

   assign access    = PSEL & PENABLE;
   assign wr_en     = access & PWRITE;
   assign wr_load   = wr_en & ~locked & (PADDR == A_LOAD);
   assign wr_ctrl   = wr_en & ~locked & (PADDR == A_CTRL);
   assign wr_intclr = wr_en & ~locked & (PADDR == A_INTCLR);
   assign wr_lock   = wr_en & (PADDR == A_LOCK);
   assign tick      = inten_q & (psc_cnt == psc_q);

   // Read mux; INTCLR is write-only and reads as zero without error.
   always_comb begin
      rd_data = '0;
      case (PADDR)
         A_LOAD:  rd_data[CNT_W-1:0]   = load_q;
         A_VALUE: rd_data[CNT_W-1:0]   = value_q;
         A_CTRL:  rd_data[PSC_W+1:0]   = {psc_q, resen_q, inten_q};
         A_RIS:   rd_data[0]           = int_raw;
         A_LOCK:  rd_data[0]           = locked;
         default: rd_data              = '0;
      endcase
   end

   assign PRDATA = (access & ~PWRITE) ? rd_data : '0;

   always_comb begin
      PSLVERR = 1'b0;
      if (access) begin
         case (PADDR)
            A_LOAD, A_CTRL, A_INTCLR: PSLVERR = PWRITE & locked;
            A_VALUE, A_RIS:           PSLVERR = PWRITE;
            A_LOCK:                   PSLVERR = 1'b0;
            default:                  PSLVERR = 1'b1;
         endcase
      end
   end

   // An accepted config write pre-empts the prescaler that edge, so a write
   // landing on a timeout cycle suppresses the interrupt/reset escalation.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         load_q    <= '1;
         value_q   <= '1;
         psc_q     <= '0;
         psc_cnt   <= '0;
         resen_q   <= 1'b0;
         inten_q   <= 1'b0;
         int_raw   <= 1'b0;
         locked    <= 1'b1;
         wdogres_q <= 1'b0;
      end else begin
         if (wr_lock) begin
            locked <= (PWDATA != UNLOCK_KEY);
         end
         if (wr_load) begin
            load_q  <= PWDATA[CNT_W-1:0];
            value_q <= PWDATA[CNT_W-1:0];
            psc_cnt <= '0;
         end else if (wr_ctrl) begin
            psc_q   <= PWDATA[PSC_W+1:2];
            resen_q <= PWDATA[1];
            inten_q <= PWDATA[0];
            psc_cnt <= '0;
            if (inten_q & ~PWDATA[0]) begin
               int_raw <= 1'b0;
            end
         end else if (wr_intclr) begin
            int_raw <= 1'b0;
            value_q <= load_q;
            psc_cnt <= '0;
         end else if (tick) begin
            psc_cnt <= '0;
            if (value_q == '0) begin
               value_q <= load_q;
               if (!int_raw) begin
                  int_raw <= 1'b1;
               end else if (resen_q) begin
                  wdogres_q <= 1'b1;
               end
            end else begin
               value_q <= value_q - CNT_ONE;
            end
         end else if (inten_q) begin
            psc_cnt <= psc_cnt + PSC_ONE;
         end
      end
   end

   assign PREADY  = 1'b1;
   assign WDOGINT = int_raw & inten_q;
   assign WDOGRES = wdogres_q;

endmodule

// File: tb/tb_apb_wdt.sv
// Bench for apb_wdt: directed scenarios plus randomized APB traffic, all checked
// against a cycle-level reference model of the watchdog's register behaviour.
module tb_apb_wdt;

   localparam logic [31:0] KEY = 32'h1ACC_E551;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [2:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        WDOGINT;
   logic        WDOGRES;

   apb_wdt #(.CNT_W(32), .PSC_W(8)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .WDOGINT (WDOGINT),
      .WDOGRES (WDOGRES)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: m_wait counts the cycles left until the next prescaled tick.
   logic [31:0] m_load;
   logic [31:0] m_value;
   logic [7:0]  m_psc;
   int          m_wait;
   bit          m_resen, m_inten, m_raw, m_res, m_locked;

   logic        obs_int;
   logic        obs_res;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_load   = '1;
      m_value  = '1;
      m_psc    = '0;
      m_wait   = 1;
      m_resen  = 1'b0;
      m_inten  = 1'b0;
      m_raw    = 1'b0;
      m_res    = 1'b0;
      m_locked = 1'b1;
   endfunction

   function automatic void model_read(input logic [2:0] a, output logic [31:0] d, output logic e);
      d = '0;
      e = 1'b0;
      case (a)
         3'd0: d = m_load;
         3'd1: d = m_value;
         3'd2: d = {22'd0, m_psc, m_resen, m_inten};
         3'd4: d = {31'd0, m_raw};
         3'd5: d = {31'd0, m_locked};
         3'd6, 3'd7: e = 1'b1;
         default: d = '0;
      endcase
   endfunction

   function automatic logic model_write_err(input logic [2:0] a);
      case (a)
         3'd0, 3'd2, 3'd3: return m_locked;
         3'd5:             return 1'b0;
         default:          return 1'b1;
      endcase
   endfunction

   function automatic void model_step(input bit wr, input logic [2:0] a, input logic [31:0] d);
      bit took = 1'b0;
      if (wr) begin
         case (a)
            3'd0: if (!m_locked) begin m_load = d; m_value = d; took = 1'b1; end
            3'd2: if (!m_locked) begin
                     if (m_inten && !d[0]) m_raw = 1'b0;
                     m_inten = d[0];
                     m_resen = d[1];
                     m_psc   = d[9:2];
                     took    = 1'b1;
                  end
            3'd3: if (!m_locked) begin m_raw = 1'b0; m_value = m_load; took = 1'b1; end
            3'd5: m_locked = (d != KEY);
            default: ;
         endcase
      end
      if (took) begin
         m_wait = int'(m_psc) + 1;
      end else if (m_inten) begin
         m_wait--;
         if (m_wait == 0) begin
            m_wait = int'(m_psc) + 1;
            if (m_value == 0) begin
               m_value = m_load;
               if (!m_raw) m_raw = 1'b1;
               else if (m_resen) m_res = 1'b1;
            end else begin
               m_value = m_value - 1;
            end
         end
      end
   endfunction

   // One PCLK cycle of bus activity; outputs are sampled on the falling edge.
   task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                input logic [2:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
      logic [31:0] exp_d;
      logic        exp_e;
      PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = d;
      @(negedge PCLK);
      rd = PRDATA;
      er = PSLVERR;
      obs_int = WDOGINT;
      obs_res = WDOGRES;
      checkOutput("wdogint", WDOGINT, m_raw & m_inten);
      checkOutput("wdogres", WDOGRES, m_res);
      if (sel && en) begin
         if (wr) begin
            checkOutput("wr_slverr", PSLVERR, model_write_err(a));
         end else begin
            model_read(a, exp_d, exp_e);
            checkOutput("rd_data", PRDATA, exp_d);
            checkOutput("rd_slverr", PSLVERR, exp_e);
         end
      end else begin
         checkOutput("idle_slverr", PSLVERR, 0);
      end
      model_step(sel && en && wr, a, d);
      @(posedge PCLK);
      #1;
   endtask

   task automatic apb_write(input logic [2:0] a, input logic [31:0] d, output logic er);
      logic [31:0] rd;
      applyStimulus(1'b1, 1'b0, 1'b1, a, d, rd, er);
      applyStimulus(1'b1, 1'b1, 1'b1, a, d, rd, er);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [31:0] d, output logic er);
      applyStimulus(1'b1, 1'b0, 1'b0, a, 32'd0, d, er);
      applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0, d, er);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, rd, er);
   endtask

   task automatic do_reset();
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(posedge PCLK);
      #1;
      model_reset();
      PRESET = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int          exp_v [9]   = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
      int          exp_i [9]   = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
      int          exp_p [4]   = '{1, 1, 1, 0};
      int          r;
      logic [2:0]  a;
      logic [31:0] wd;

      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      obs_int = 1'b0; obs_res = 1'b0;
      model_reset();
      do_reset();

      $display("[TB] reset values");
      checkOutput("pready", PREADY, 1);
      apb_read(3'd0, d, e); checkOutput("rst_load", d, 32'hFFFF_FFFF);
      apb_read(3'd1, d, e); checkOutput("rst_value", d, 32'hFFFF_FFFF);
      apb_read(3'd2, d, e); checkOutput("rst_ctrl", d, 0);
      apb_read(3'd4, d, e); checkOutput("rst_ris", d, 0);
      apb_read(3'd5, d, e); checkOutput("rst_lock", d, 1);
      checkOutput("rst_int", obs_int, 0);
      checkOutput("rst_res", obs_res, 0);

      $display("[TB] lock behaviour");
      apb_write(3'd0, 32'd5, e); checkOutput("locked_load_err", e, 1);
      apb_read(3'd0, d, e);      checkOutput("locked_load_kept", d, 32'hFFFF_FFFF);
      apb_write(3'd5, KEY, e);   checkOutput("unlock_err", e, 0);
      apb_write(3'd0, 32'd5, e); checkOutput("unlocked_load_err", e, 0);
      apb_read(3'd0, d, e);      checkOutput("unlocked_load", d, 5);

      $display("[TB] timeout and reset escalation");
      apb_write(3'd0, 32'd3, e);
      apb_write(3'd2, 32'd3, e);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'd0, d, e);
         checkOutput("seq_value", d, exp_v[i]);
         checkOutput("seq_int", obs_int, exp_i[i]);
         checkOutput("seq_res", obs_res, (i == 8) ? 1 : 0);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      idle_cycles(6);
      checkOutput("res_sticky", obs_res, 1);
      do_reset();
      idle_cycles(1);
      checkOutput("res_cleared", obs_res, 0);

      $display("[TB] prescaler and INTCLR on timeout edge");
      apb_write(3'd5, KEY, e);
      apb_write(3'd0, 32'd1, e);
      apb_write(3'd2, 32'd9, e);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'd0, d, e);
         checkOutput("psc_value", d, exp_p[i]);
      end
      apb_write(3'd3, 32'd0, e);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'd0, d, e);
      checkOutput("intclr_value", d, 1);
      checkOutput("intclr_noint", obs_int, 0);
      PSEL = 1'b0; PENABLE = 1'b0;

      apb_read(3'd6, d, e);
      checkOutput("unmapped_data", d, 0);
      checkOutput("unmapped_err", e, 1);

      $display("[TB] reset during pending interrupt");
      for (int i = 0; i < 20 && !obs_int; i++) idle_cycles(1);
      checkOutput("int_reached", obs_int, 1);
      do_reset();
      idle_cycles(1);
      checkOutput("rst_int_clear", obs_int, 0);
      apb_read(3'd5, d, e);
      checkOutput("rst_relock", d, 1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            do_reset();
         end else if (r < 25) begin
            idle_cycles($urandom_range(1, 4));
         end else if (r < 55) begin
            a = 3'($urandom_range(0, 7));
            apb_read(a, d, e);
         end else begin
            a = 3'($urandom_range(0, 7));
            case (a)
               3'd0: wd = 32'($urandom_range(0, 6));
               3'd2: wd = {22'd0, 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) != 0)};
               3'd5: wd = ($urandom_range(0, 1) != 0) ? KEY : $urandom;
               default: wd = $urandom;
            endcase
            apb_write(a, wd, e);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
